// File: rtl/nemu_measure_ctrl_pkg.sv
// Shared NEMU definitions: run-sequencer state encoding, default counter width, helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nemu_measure_ctrl_pkg;

    // Default width of phase, timestamp and packet counters across NEMU blocks.
    localparam int NEMU_CNT_W = 32;

    // Run-sequencer states; encoding is visible to software through o_state.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } nemu_state_e;

    // A run is in progress from the first warm-up cycle until the drain finishes.
    function automatic logic nemu_is_busy(nemu_state_e st);
        return (st == ST_WARMUP) || (st == ST_MEASURE) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/nemu_measure_ctrl_if.sv
// Control/status bundle between the run sequencer and its host plus the network taps.
// Latency: n/a (wires only).
// Backpressure: none; tx/rx valid vectors are observe-only.
interface nemu_measure_ctrl_if #(
    parameter int PORTS = 16,
    parameter int CNT_W = 32
);
    // Host commands and run configuration
    logic             i_start;
    logic             i_abort;
    logic [CNT_W-1:0] i_warmup_cycles;
    logic [CNT_W-1:0] i_measure_cycles;
    logic [CNT_W-1:0] i_drain_timeout;
    // Per-port network taps
    logic [PORTS-1:0] i_tx_valid;
    logic [PORTS-1:0] i_rx_valid;
    logic [PORTS-1:0] i_fifo_error;
    // Sequencer outputs
    logic [CNT_W-1:0] o_timestamp;
    logic             o_inject_en;
    logic             o_measure;
    logic             o_busy;
    logic             o_done;
    logic             o_timeout;
    logic             o_err;
    logic [2:0]       o_state;
    logic [CNT_W-1:0] o_meas_tx;
    logic [CNT_W-1:0] o_inflight;

    modport master (
        output i_start, i_abort, i_warmup_cycles, i_measure_cycles, i_drain_timeout,
               i_tx_valid, i_rx_valid, i_fifo_error,
        input  o_timestamp, o_inject_en, o_measure, o_busy, o_done, o_timeout, o_err,
               o_state, o_meas_tx, o_inflight
    );

    modport slave (
        input  i_start, i_abort, i_warmup_cycles, i_measure_cycles, i_drain_timeout,
               i_tx_valid, i_rx_valid, i_fifo_error,
        output o_timestamp, o_inject_en, o_measure, o_busy, o_done, o_timeout, o_err,
               o_state, o_meas_tx, o_inflight
    );
endinterface

// File: rtl/nemu_popcount.sv
// Counts set bits of a per-port valid vector.
// Latency: combinational.
// Backpressure: none.
module nemu_popcount #(
    parameter int PORTS = 16,
    parameter int CW    = $clog2(PORTS + 1)
) (
    input  logic [PORTS-1:0] i_vec,
    output logic [CW-1:0]    o_cnt
);

    // Simple adder chain; PORTS is small so depth is not a concern.
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < PORTS; i++) begin
            o_cnt = o_cnt + CW'(i_vec[i]);
        end
    end

endmodule

// File: rtl/nemu_measure_ctrl.sv
// Run sequencer: warm-up, measurement window, drain, done; tracks in-flight packets.
// Latency: all outputs registered; an input affects outputs one cycle after it is sampled.
// Backpressure: none; tx/rx are counted every cycle and never stalled.
module nemu_measure_ctrl
    import nemu_measure_ctrl_pkg::*;
#(
    parameter int PORTS = 16,
    parameter int CNT_W = NEMU_CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    nemu_measure_ctrl_if.slave bus
);

    localparam int                PC_W    = $clog2(PORTS + 1);
    localparam logic [CNT_W-1:0]  ONE     = CNT_W'(1);
    localparam logic [CNT_W:0]    CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    nemu_state_e      state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;       // down-counter in WARMUP/MEASURE, up-counter in DRAIN
    logic [CNT_W-1:0] meas_len_q, meas_len_d; // measurement length captured at start
    logic [CNT_W-1:0] tmo_len_q, tmo_len_d;   // drain timeout captured at start
    logic [CNT_W-1:0] ts_q, ts_d;
    logic [CNT_W-1:0] meas_tx_q, meas_tx_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             timeout_q, timeout_d;
    logic             err_q, err_d;
    logic             start_run;

    logic [PC_W-1:0]  tx_cnt;
    logic [PC_W-1:0]  rx_cnt;
    logic [CNT_W:0]   fl_sum;
    logic [CNT_W:0]   fl_diff;
    logic [CNT_W:0]   mt_sum;

    nemu_popcount #(.PORTS(PORTS), .CW(PC_W)) u_pop_tx (
        .i_vec (bus.i_tx_valid),
        .o_cnt (tx_cnt)
    );

    nemu_popcount #(.PORTS(PORTS), .CW(PC_W)) u_pop_rx (
        .i_vec (bus.i_rx_valid),
        .o_cnt (rx_cnt)
    );

    // Next-state logic: abort wins, otherwise phase expiry / drain completion / start.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        meas_len_d = meas_len_q;
        tmo_len_d  = tmo_len_q;
        timeout_d  = timeout_q;
        start_run  = 1'b0;
        if ((state_q != ST_IDLE) && bus.i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.i_start) begin
                        start_run  = 1'b1;
                        meas_len_d = bus.i_measure_cycles;
                        tmo_len_d  = bus.i_drain_timeout;
                        timeout_d  = 1'b0;
                        if (bus.i_warmup_cycles != '0) begin
                            state_d = ST_WARMUP;
                            phase_d = bus.i_warmup_cycles - ONE;
                        end else if (bus.i_measure_cycles != '0) begin
                            state_d = ST_MEASURE;
                            phase_d = bus.i_measure_cycles - ONE;
                        end else begin
                            state_d = ST_DRAIN;
                            phase_d = '0;
                        end
                    end
                end
                ST_WARMUP: begin
                    if (phase_q == '0) begin
                        if (meas_len_q != '0) begin
                            state_d = ST_MEASURE;
                            phase_d = meas_len_q - ONE;
                        end else begin
                            state_d = ST_DRAIN;
                            phase_d = '0;
                        end
                    end else begin
                        phase_d = phase_q - ONE;
                    end
                end
                ST_MEASURE: begin
                    if (phase_q == '0) begin
                        state_d = ST_DRAIN;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q - ONE;
                    end
                end
                ST_DRAIN: begin
                    // Empty network takes precedence over a coincident timeout.
                    if ((inflight_q == '0) && (tx_cnt == '0) && (rx_cnt == '0)) begin
                        state_d = ST_DONE;
                    end else if ((tmo_len_q != '0) && (phase_q == tmo_len_q - ONE)) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        phase_d = phase_q + ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Timestamp, in-flight accounting, measured-tx count and sticky error.
    always_comb begin
        ts_d       = ts_q + ONE;
        inflight_d = inflight_q;
        meas_tx_d  = meas_tx_q;
        err_d      = err_q;
        fl_sum     = {1'b0, inflight_q} + (CNT_W+1)'(tx_cnt);
        fl_diff    = fl_sum - (CNT_W+1)'(rx_cnt);
        mt_sum     = {1'b0, meas_tx_q} + (CNT_W+1)'(tx_cnt);
        if (start_run) begin
            inflight_d = '0;
            meas_tx_d  = '0;
            err_d      = 1'b0;
        end else if (state_q != ST_IDLE) begin
            // More ejections than the count allows means lost accounting: clamp and flag.
            if (fl_sum < (CNT_W+1)'(rx_cnt)) begin
                inflight_d = '0;
                err_d      = 1'b1;
            end else if (fl_diff > CNT_MAX) begin
                inflight_d = '1;
            end else begin
                inflight_d = fl_diff[CNT_W-1:0];
            end
            if (state_q == ST_MEASURE) begin
                meas_tx_d = (mt_sum > CNT_MAX) ? '1 : mt_sum[CNT_W-1:0];
            end
            if (nemu_is_busy(state_q) && (bus.i_fifo_error != '0)) begin
                err_d = 1'b1;
            end
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            meas_len_q <= '0;
            tmo_len_q  <= '0;
            ts_q       <= '0;
            meas_tx_q  <= '0;
            inflight_q <= '0;
            timeout_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            meas_len_q <= meas_len_d;
            tmo_len_q  <= tmo_len_d;
            ts_q       <= ts_d;
            meas_tx_q  <= meas_tx_d;
            inflight_q <= inflight_d;
            timeout_q  <= timeout_d;
            err_q      <= err_d;
        end
    end

    // Moore decodes of the registered state plus registered counters.
    assign bus.o_state     = state_q;
    assign bus.o_inject_en = (state_q == ST_WARMUP) || (state_q == ST_MEASURE);
    assign bus.o_measure   = (state_q == ST_MEASURE) || (state_q == ST_DRAIN);
    assign bus.o_busy      = nemu_is_busy(state_q);
    assign bus.o_done      = (state_q == ST_DONE);
    assign bus.o_timeout   = timeout_q;
    assign bus.o_err       = err_q;
    assign bus.o_timestamp = ts_q;
    assign bus.o_meas_tx   = meas_tx_q;
    assign bus.o_inflight  = inflight_q;

endmodule
